// File: rtl/io_pkg.sv
// Shared definitions for the board IO block: register addresses, scan states and the
// hex-to-seven-segment table (active-low cathodes, {dp,g..a}).
package io_pkg;

    localparam int unsigned IO_WIDTH = 16;

    localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;
    localparam logic [31:0] SEG_ADDR = 32'hFFFF_FC80;

    typedef enum logic [1:0] {
        Dig0 = 2'd0,
        Dig1 = 2'd1,
        Dig2 = 2'd2,
        Dig3 = 2'd3
    } scan_state_e;

    // Decimal point is held off (bit 7 high) in every entry.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stability counter; a switch value is accepted only
// after it has been seen unchanged for DEBOUNCE_CYCLES consecutive cycles.
module switch_debounce
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [IO_WIDTH-1:0] sw_raw_i,
    output logic [IO_WIDTH-1:0] sw_db_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [IO_WIDTH-1:0] sync1_q, sync2_q;
    logic [IO_WIDTH-1:0] cand_q, cand_d;
    logic [IO_WIDTH-1:0] db_q, db_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            // Counter saturates; the stable candidate keeps being published.
            db_d = cand_q;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
        end else begin
            sync1_q <= sw_raw_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign sw_db_o = db_q;

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped board IO: LED register, debounced switch readback and a multiplexed
// four-digit seven-segment display driven from a 16-bit hex value.
module io_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SCAN_CYCLES     = 100000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [15:0] switch,
    output logic [15:0] io_rdata,
    output logic [15:0] led,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned ScanW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_CYCLES - 1);

    logic [IO_WIDTH-1:0] led_q, led_d;
    logic [IO_WIDTH-1:0] seg_val_q, seg_val_d;
    logic [IO_WIDTH-1:0] sw_db;
    logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
    scan_state_e         state_q, state_d;
    logic [3:0]          nibble;
    logic                unused_wdata;

    assign unused_wdata = ^wdata[31:16];

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_switch_debounce (
        .clock   (clock),
        .rst     (rst),
        .sw_raw_i(switch),
        .sw_db_o (sw_db)
    );

    always_comb begin
        led_d     = led_q;
        seg_val_d = seg_val_q;
        if (io_write) begin
            if (addr == LED_ADDR) led_d = wdata[15:0];
            if (addr == SEG_ADDR) seg_val_d = wdata[15:0];
        end
    end

    // Reads see register contents before any same-cycle write lands.
    always_comb begin
        io_rdata = '0;
        if (io_read) begin
            if (addr == SW_ADDR)       io_rdata = sw_db;
            else if (addr == LED_ADDR) io_rdata = led_q;
            else if (addr == SEG_ADDR) io_rdata = seg_val_q;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + ScanW'(1);
        state_d    = state_q;
        if (scan_cnt_q == ScanMax) begin
            scan_cnt_d = '0;
            unique case (state_q)
                Dig0: state_d = Dig1;
                Dig1: state_d = Dig2;
                Dig2: state_d = Dig3;
                Dig3: state_d = Dig0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            led_q      <= '0;
            seg_val_q  <= '0;
            scan_cnt_q <= '0;
            state_q    <= Dig0;
        end else begin
            led_q      <= led_d;
            seg_val_q  <= seg_val_d;
            scan_cnt_q <= scan_cnt_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        an     = 4'b1111;
        nibble = seg_val_q[3:0];
        unique case (state_q)
            Dig0: begin an = 4'b1110; nibble = seg_val_q[3:0];   end
            Dig1: begin an = 4'b1101; nibble = seg_val_q[7:4];   end
            Dig2: begin an = 4'b1011; nibble = seg_val_q[11:8];  end
            Dig3: begin an = 4'b0111; nibble = seg_val_q[15:12]; end
        endcase
        seg = hex_to_seg(nibble);
    end

    assign led = led_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl with a scoreboard of expected output values.
module tb_io_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned SC = 3;
    localparam logic [31:0] A_LED = 32'hFFFF_FC60;
    localparam logic [31:0] A_SW  = 32'hFFFF_FC70;
    localparam logic [31:0] A_SEG = 32'hFFFF_FC80;

    logic        clock = 1'b0;
    logic        rst;
    logic        io_read, io_write;
    logic [31:0] addr, wdata;
    logic [15:0] switch;
    logic [15:0] io_rdata, led;
    logic [7:0]  seg;
    logic [3:0]  an;

    always #5 clock = ~clock;

    io_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SCAN_CYCLES    (SC)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .io_read (io_read),
        .io_write(io_write),
        .addr    (addr),
        .wdata   (wdata),
        .switch  (switch),
        .io_rdata(io_rdata),
        .led     (led),
        .seg     (seg),
        .an      (an)
    );

    typedef enum int {SigRdata, SigLed, SigSeg, SigAn} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] seg_m    = 16'h0;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        io_read  = rd;
        io_write = wr;
        addr     = a;
        wdata    = d;
    endtask

    task automatic push(input string tag, input sig_e sig, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    // Scan position follows purely from cycles since reset release.
    task automatic push_scan(input string tag);
        int          st;
        logic [3:0]  nib;
        logic [3:0]  an_e;
        st   = (cyc / SC) % 4;
        nib  = seg_m[4*st +: 4];
        an_e = ~(4'b0001 << st);
        push({tag, "_an"}, SigAn, {12'h0, an_e});
        push({tag, "_seg"}, SigSeg, {8'h0, seg_of(nib)});
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                SigRdata: obs = io_rdata;
                SigLed:   obs = led;
                SigSeg:   obs = {8'h0, seg};
                default:  obs = {12'h0, an};
            endcase
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h (cycle %0d)", e.tag, obs, e.val, cyc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus(1'b0, 1'b0, 32'h0, 32'h0);
        switch = 16'h0;
        #12;
        bus(1'b1, 1'b0, A_SW, 32'h0);
        push("rst_led", SigLed, 16'h0);
        push("rst_an", SigAn, 16'h000E);
        push("rst_seg", SigSeg, 16'h00C0);
        push("rst_sw", SigRdata, 16'h0);
        drain();
        tick();
        rst = 1'b1;
        cyc = 0;

        // Short switch glitch must never be accepted.
        switch = 16'h0001;
        repeat (3) tick();
        switch = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            push("glitch", SigRdata, 16'h0);
            drain();
        end

        // LED write, upper data bits ignored.
        bus(1'b0, 1'b1, A_LED, 32'h1234_A5A5);
        push("led_pre", SigLed, 16'h0);
        drain();
        tick();
        bus(1'b1, 1'b0, A_LED, 32'h0);
        push("led_wr", SigLed, 16'hA5A5);
        push("led_rd", SigRdata, 16'hA5A5);
        drain();

        // Writes to the switch address or unmapped addresses do nothing.
        bus(1'b0, 1'b1, A_SW, 32'h0000_FFFF);
        tick();
        bus(1'b0, 1'b1, 32'hFFFF_FC64, 32'h0000_1111);
        tick();
        bus(1'b0, 1'b1, 32'h7FFF_FC60, 32'h0000_2222);
        tick();
        bus(1'b1, 1'b0, A_LED, 32'h0);
        push("unmap_led", SigLed, 16'hA5A5);
        push("unmap_rd", SigRdata, 16'hA5A5);
        drain();
        bus(1'b1, 1'b0, A_SW, 32'h0);
        push("sw_wr_ign", SigRdata, 16'h0);
        drain();
        bus(1'b1, 1'b0, 32'h0000_FC60, 32'h0);
        push("partial_addr", SigRdata, 16'h0);
        drain();
        bus(1'b0, 1'b0, A_LED, 32'h0);
        push("no_read", SigRdata, 16'h0);
        drain();

        // Same-cycle read and write returns the old value.
        bus(1'b0, 1'b1, A_LED, 32'h0000_0003);
        tick();
        bus(1'b1, 1'b1, A_LED, 32'h0000_00F0);
        push("rw_same", SigRdata, 16'h0003);
        drain();
        tick();
        bus(1'b1, 1'b0, A_LED, 32'h0);
        push("rw_led", SigLed, 16'h00F0);
        push("rw_rd", SigRdata, 16'h00F0);
        drain();

        // Clean switch change: 6 cycles of old value, new value from cycle 7.
        switch = 16'h00FF;
        bus(1'b1, 1'b0, A_SW, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            push("db_rise", SigRdata, (k >= 7) ? 16'h00FF : 16'h0000);
            drain();
        end

        // Seven-segment scan from the start of digit 0.
        bus(1'b0, 1'b1, A_SEG, 32'hABCD_4321);
        tick();
        seg_m = 16'h4321;
        bus(1'b0, 1'b0, 32'h0, 32'h0);
        while ((cyc % (4 * SC)) != 0) tick();
        for (int i = 0; i < 4 * SC; i++) begin
            push_scan("scan");
            drain();
            tick();
        end

        // Mid-scan write: scan position keeps running, new nibbles from the next digit.
        while ((cyc % (4 * SC)) != SC + 1) tick();
        bus(1'b0, 1'b1, A_SEG, 32'h0000_8765);
        tick();
        seg_m = 16'h8765;
        bus(1'b1, 1'b0, A_SEG, 32'h0);
        push("seg_rd", SigRdata, 16'h8765);
        drain();
        while ((cyc % SC) != 0) tick();
        for (int i = 0; i < 2 * SC; i++) begin
            push_scan("scan2");
            drain();
            tick();
        end

        // Asynchronous reset mid-scan with switches accepted.
        while ((cyc % (4 * SC)) != 2 * SC + 1) tick();
        #2;
        rst = 1'b0;
        seg_m = 16'h0;
        bus(1'b1, 1'b0, A_SW, 32'h0);
        push("arst_led", SigLed, 16'h0);
        push("arst_an", SigAn, 16'h000E);
        push("arst_seg", SigSeg, 16'h00C0);
        push("arst_sw", SigRdata, 16'h0);
        drain();
        tick();
        tick();
        push("arst_hold_an", SigAn, 16'h000E);
        push("arst_hold_sw", SigRdata, 16'h0);
        drain();
        rst = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            push("restart_sw", SigRdata, (k >= 7) ? 16'h00FF : 16'h0000);
            push_scan("restart");
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd1000000, number of stable cycles before a switch change is accepted.
REQ-002 Parameter SCAN_CYCLES, default 17'd100000, cycles each seven-segment digit is driven.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 io_read  input  1  IO read strobe from the memory/IO address decoder.
REQ-006 io_write  input  1  IO write strobe from the memory/IO address decoder.
REQ-007 addr  input  32  byte address from the ALU result.
REQ-008 wdata  input  32  store data from register read port 2.
REQ-009 switch  input  16  raw board switches, asynchronous to clock.
REQ-010 io_rdata  output  16  read data returned to the memory/IO mux.
REQ-011 led  output  16  LED drive, active-high.
REQ-012 seg  output  8  seven-segment cathodes {dp,g..a}, active-low.
REQ-013 an  output  4  digit enables, active-low, one-hot.

Function
REQ-014 Decode addr with a full 32-bit compare: LED_ADDR 32'hFFFF_FC60, SW_ADDR 32'hFFFF_FC70, SEG_ADDR 32'hFFFF_FC80. Any other address selects nothing.
REQ-015 Writes: with io_write=1 at a rising edge, LED_ADDR loads led_reg<=wdata[15:0] and SEG_ADDR loads seg_val<=wdata[15:0]. The new value is visible on the outputs after exactly 1 cycle. wdata[31:16] is ignored.
REQ-016 Writes to SW_ADDR or to an unmapped address have no effect.
REQ-017 Reads are combinational:
- io_rdata = sw_db when io_read=1 and addr=SW_ADDR.
- io_rdata = led_reg for LED_ADDR.
- io_rdata = seg_val for SEG_ADDR.
- io_rdata = 16'h0000 otherwise, including when io_read=0.
REQ-018 A simultaneous io_read and io_write to the same address returns the pre-write value in that cycle.
REQ-019 Switch path: a 2-flop synchroniser produces sw_sync.
- A candidate register sw_cand and a counter db_cnt track sw_sync.
- If sw_sync != sw_cand: sw_cand<=sw_sync and db_cnt<=0.
- Otherwise, if db_cnt < DEBOUNCE_CYCLES-1: db_cnt increments.
- When db_cnt = DEBOUNCE_CYCLES-1 and sw_sync = sw_cand: sw_db<=sw_cand and db_cnt holds (no wrap).
REQ-020 A clean switch change reaches sw_db in 2+DEBOUNCE_CYCLES+1 cycles. Any glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches sw_db.
REQ-021 Scan FSM: four states DIG0..DIG3.
- scan_cnt counts 0..SCAN_CYCLES-1 and then wraps to 0.
- On each wrap the state advances DIG0->DIG1->DIG2->DIG3->DIG0.
REQ-022 In state DIGn: an = ~(4'b0001<<n), and seg = hex pattern of seg_val[4n+3:4n] with the decimal point off (seg[7]=1).
REQ-023 A write to SEG_ADDR does not reset the scan FSM; the new nibbles appear on the next displayed digit.
REQ-024 led = led_reg directly; no combinational path from inputs to led, seg or an.

Reset
REQ-025 While rst=0, independent of clock:
- led_reg=0, seg_val=0, sw_sync stages=0, sw_cand=0, sw_db=0, db_cnt=0, scan_cnt=0.
- Scan state=DIG0, so an=4'b1110 and seg=8'hC0 (digit "0").
REQ-026 Reset asserted mid-debounce or mid-scan discards the partial count. Operation restarts from REQ-025 values on the first rising edge after rst returns to 1.

Structure
REQ-027 Package io_pkg holds LED_ADDR, SW_ADDR, SEG_ADDR, IO_WIDTH=16, the scan-state encoding and the 16-entry hex-to-segment table.
REQ-028 The synchroniser and debounce logic are one sub-module, switch_debounce (16-bit, parameter DEBOUNCE_CYCLES), instantiated once. The remaining logic is in io_ctrl.

Verification (DEBOUNCE_CYCLES=4, SCAN_CYCLES=3)
REQ-029 Write 32'h1234_A5A5 to FFFF_FC60 -> led=16'hA5A5 one cycle later; a read of FC60 returns 16'hA5A5.
REQ-030 switch 0->16'h00FF held -> io_rdata at FC70 reads 16'h0000 for 6 cycles, then 16'h00FF from cycle 7.
REQ-031 switch pulses 16'h0001 for 3 cycles, then returns to 0 -> sw_db stays 16'h0000 indefinitely.
REQ-032 Write 16'h4321 to FC80 -> an sequence 1110,1101,1011,0111 every 3 cycles; seg sequence 8'hF9,8'hA4,8'hB0,8'h99.
REQ-033 Read and write of FC60 in the same cycle (old 16'h0003, new 16'h00F0) -> io_rdata=16'h0003 that cycle, led=16'h00F0 the next cycle.
REQ-034 Assert rst=0 mid-scan with sw_db=16'h00FF -> immediately led=0, an=4'b1110, seg=8'hC0, and a read of FC70 returns 0.
